data_pair_map_b1: RTL and testbench
===================================

# data_pair_map_b1

Parametrised key→value associative table with explicit occupancy tracking, lookup hit/miss reporting and full-table handling. It is the next generation of the team's data-pair map. It adds:
- independent key and value widths;
- an output stage with full valid/ready backpressure;
- an occupancy count;
- a defined policy when the table is full.

It sits between a protocol front end that learns ID pairs and the datapath that translates IDs on the fly.

## Interface
Parameters:
- KEY_W, 8: key width.
- VAL_W, 8: value width.
- DEPTH, 8: entry count, power of two, ≥2.

Ports:
- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wr_valid / wr_ready  in / out  1 / 1  insert/update handshake.
- wr_key  in  KEY_W  key to insert.
- wr_val  in  VAL_W  value to store.
- rd_valid / rd_ready  in / out  1 / 1  lookup request handshake.
- rd_key  in  KEY_W  lookup key.
- kdel_valid / kdel_ready  in / out  1 / 1  delete-by-key handshake.
- kdel_key  in  KEY_W  key to remove.
- vdel_valid / vdel_ready  in / out  1 / 1  delete-by-value handshake.
- vdel_val  in  VAL_W  value whose entries are removed.
- out_valid / out_ready  out / in  1 / 1  lookup result handshake.
- out_val  out  VAL_W  looked-up value; 0 on miss.
- out_hit  out  1  1 = key present.
- out_key  out  KEY_W  echo of the looked-up key.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.
- full  out  1  occupancy == DEPTH.

## Operation
**Storage.** Each entry holds key, val and a vld bit.

**Write (wr_valid && wr_ready).**
- If the key matches a valid entry, that entry's value is updated in place. Occupancy is unchanged.
- Otherwise the key and value go into the lowest-index invalid entry, and occupancy increments.

**Full table, new key (no matching entry).** Behaviour depends on the build; see Configuration.

**Deletes.**
- kdel_ready = vdel_ready = !wr_valid. Write has priority; deletes stall while a write is presented.
- A key delete clears the vld bit of the matching entry.
- A value delete clears the vld bit of every entry whose value matches.
- Both deletes may fire in the same cycle. The union of matches is cleared, and occupancy decrements by the number of distinct entries cleared.
- Deleting an absent key or value is accepted and has no effect.

**Lookup.**
- rd_ready = !out_valid || out_ready.
- On accept, the request is compared against the table state as of before this cycle's write or delete edge.
- out_hit and out_val come from the matching valid entry. On a miss, out_hit=0 and out_val=0.

**Uniqueness.** Keys are unique among valid entries. Values may repeat.

## Timing
**Reset values.** Asserting rst clears asynchronously:
- all vld bits, keys and values;
- occupancy=0, full=0;
- out_valid=0, out_val=0, out_hit=0, out_key=0.

A lookup result in flight at reset is lost.

**Latency.**
- Writes and deletes take effect at the next rising edge. occupancy and full are registered and reflect that edge.
- Lookup latency is 1 cycle: out_valid rises on the edge after rd_valid && rd_ready.
- out_* hold stable while out_valid && !out_ready.
- Back-to-back lookups sustain one per cycle when out_ready=1.

**Same-cycle interactions.**
- A lookup of key K in the same cycle as a write of K returns the old mapping. A lookup one cycle later returns the new one.
- A lookup in the same cycle as a delete of its key still hits.

## Configuration
Macro DATA_PAIR_MAP_B1_EVICT_EN:
- **Defined.** wr_ready is always 1. A new key written while full replaces the entry at a victim pointer. The pointer resets to 0, advances by one per eviction and wraps DEPTH-1→0. Occupancy stays at DEPTH. Update-in-place and insert into a free slot do not move the pointer.
- **Undefined.** wr_ready = !full || (wr_key matches a valid entry). A new key on a full table is back-pressured until a delete frees a slot. The victim pointer is not built.

## Test plan
All scenarios use DEPTH=4, KEY_W=8, VAL_W=8.

- **Insert and lookup:** write (0x11→0xA1), (0x22→0xB2); look up 0x22 → out_hit=1, out_val=0xB2, 1 cycle later. occupancy=2.
- **Update and miss:** write 0x11→0xC3, then look up 0x11 → 0xC3, occupancy still 2. Look up 0x99 → out_hit=0, out_val=0, out_key=0x99.
- **Deletes:** write keys 0x01..0x04 all with value 0x55, then vdel 0x55 → occupancy=0, full=0. Refill, then same-cycle kdel 0x02 and vdel matching only key 0x03 → occupancy=2.
- **Full policy:** with 4 entries present, write key 0x77.
  - Without the macro: wr_ready=0 until kdel of 0x01, then the insert lands in index 0.
  - With the macro: accepted immediately and evicts index 0; a second new key evicts index 1.
- **Backpressure and overlap:** hold out_ready=0 with 3 lookups queued → rd_ready=0 after the first, and out_* stay stable. A write plus a same-key lookup in one cycle returns the pre-write value.
- **Reset mid-operation:** assert rst while out_valid=1 and the table holds 3 entries → out_valid=0 and occupancy=0 immediately. A lookup of any prior key misses after reset release.

Source files
------------

// File: rtl/data_pair_map_b1.sv
// Key->value table with occupancy tracking; writes/deletes land on the next edge, lookups return after 1 cycle under out_valid/out_ready backpressure.
// Build with DATA_PAIR_MAP_B1_EVICT_EN to replace a round-robin victim on a full-table insert instead of stalling wr_ready.
module data_pair_map_b1 #(
  parameter int KEY_W = 8,
  parameter int VAL_W = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [KEY_W-1:0]         wr_key,
  input  logic [VAL_W-1:0]         wr_val,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [KEY_W-1:0]         rd_key,
  input  logic                     kdel_valid,
  output logic                     kdel_ready,
  input  logic [KEY_W-1:0]         kdel_key,
  input  logic                     vdel_valid,
  output logic                     vdel_ready,
  input  logic [VAL_W-1:0]         vdel_val,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VAL_W-1:0]         out_val,
  output logic                     out_hit,
  output logic [KEY_W-1:0]         out_key,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             vld;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } entry_t;

  entry_t tbl [DEPTH];

  logic [DEPTH-1:0] wr_match;
  logic [DEPTH-1:0] rd_match;
  logic [DEPTH-1:0] kdel_match;
  logic [DEPTH-1:0] vdel_match;
  logic [DEPTH-1:0] clr_mask;
  logic             wr_hit;
  logic             rd_hit;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] wr_tgt;
  logic [VAL_W-1:0] rd_val_sel;
  logic [CNT_W-1:0] clr_cnt;
  logic [CNT_W-1:0] occ_next;
  logic             wr_fire;
  logic             rd_fire;
  logic             kdel_fire;
  logic             vdel_fire;
  logic             wr_new;

  always_comb begin
    wr_match   = '0;
    rd_match   = '0;
    kdel_match = '0;
    vdel_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_match[i]   = tbl[i].vld && (tbl[i].key == wr_key);
      rd_match[i]   = tbl[i].vld && (tbl[i].key == rd_key);
      kdel_match[i] = tbl[i].vld && (tbl[i].key == kdel_key);
      vdel_match[i] = tbl[i].vld && (tbl[i].val == vdel_val);
    end
  end

  assign wr_hit = |wr_match;
  assign rd_hit = |rd_match;

  // Keys are unique among valid entries, so at most one match bit is set.
  always_comb begin
    wr_idx     = '0;
    rd_val_sel = '0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_match[i]) wr_idx = IDX_W'(i);
      if (rd_match[i]) rd_val_sel = tbl[i].val;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!tbl[i].vld) free_idx = IDX_W'(i);
    end
  end

`ifdef DATA_PAIR_MAP_B1_EVICT_EN
  logic [IDX_W-1:0] victim;

  assign wr_ready = 1'b1;
  assign wr_tgt   = full ? victim : free_idx;

  // Wraps DEPTH-1 -> 0 naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      victim <= '0;
    end else if (wr_new && full) begin
      victim <= victim + 1'b1;
    end
  end
`else
  assign wr_ready = !full || wr_hit;
  assign wr_tgt   = free_idx;
`endif

  assign kdel_ready = !wr_valid;
  assign vdel_ready = !wr_valid;
  assign rd_ready   = !out_valid || out_ready;

  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign kdel_fire = kdel_valid && kdel_ready;
  assign vdel_fire = vdel_valid && vdel_ready;
  assign wr_new    = wr_fire && !wr_hit;

  assign clr_mask = (kdel_fire ? kdel_match : '0) | (vdel_fire ? vdel_match : '0);

  always_comb begin
    clr_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      clr_cnt = clr_cnt + CNT_W'(clr_mask[i]);
    end
  end

  // Writes and deletes are mutually exclusive (deletes stall on wr_valid).
  always_comb begin
    occ_next = occupancy - clr_cnt;
    if (wr_new && !full) occ_next = occupancy + 1'b1;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_mask[i]) tbl[i].vld <= 1'b0;
      end
      if (wr_fire) begin
        if (wr_hit) begin
          tbl[wr_idx].val <= wr_val;
        end else begin
          tbl[wr_tgt].vld <= 1'b1;
          tbl[wr_tgt].key <= wr_key;
          tbl[wr_tgt].val <= wr_val;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
      full      <= 1'b0;
    end else begin
      occupancy <= occ_next;
      full      <= (occ_next == CNT_W'(DEPTH));
    end
  end

  // Lookup sees the table as it stood before this edge's write/delete.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_val   <= '0;
      out_key   <= '0;
    end else if (rd_fire) begin
      out_valid <= 1'b1;
      out_hit   <= rd_hit;
      out_val   <= rd_hit ? rd_val_sel : '0;
      out_key   <= rd_key;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_pair_map_b1.sv
// Self-checking bench for data_pair_map_b1 at DEPTH=4, KEY_W=VAL_W=8; lookup results checked through an ordered scoreboard.
module tb_data_pair_map_b1;

  logic       clock = 1'b0;
  logic       rst;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_key, wr_val;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_key;
  logic       kdel_valid, kdel_ready;
  logic [7:0] kdel_key;
  logic       vdel_valid, vdel_ready;
  logic [7:0] vdel_val;
  logic       out_valid, out_ready;
  logic [7:0] out_val;
  logic       out_hit;
  logic [7:0] out_key;
  logic [2:0] occupancy;
  logic       full;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic       hit;
    logic [7:0] val;
    logic [7:0] key;
  } exp_t;

  exp_t sb [$];

  always #5 clock = ~clock;

  data_pair_map_b1 #(.KEY_W(8), .VAL_W(8), .DEPTH(4)) dut (
    .clock(clock), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_key(wr_key), .wr_val(wr_val),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_key(rd_key),
    .kdel_valid(kdel_valid), .kdel_ready(kdel_ready), .kdel_key(kdel_key),
    .vdel_valid(vdel_valid), .vdel_ready(vdel_ready), .vdel_val(vdel_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_hit(out_hit), .out_key(out_key),
    .occupancy(occupancy), .full(full)
  );

  // Scoreboard: every accepted output beat is matched against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected key=%h hit=%b val=%h, no result expected", out_key, out_hit, out_val);
      end else begin
        e = sb.pop_front();
        if ({out_hit, out_val, out_key} !== e) begin
          errors++;
          $display("FAIL out_result got hit=%b val=%h key=%h required hit=%b val=%h key=%h",
                   out_hit, out_val, out_key, e.hit, e.val, e.key);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [7:0] k, input logic [7:0] v);
    bit ok = 0;
    wr_valid = 1'b1; wr_key = k; wr_val = v;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clock);
      ok = wr_ready;
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL wr_accept key=%h wr_ready=%b required 1", k, wr_ready);
    end
    @(posedge clock); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [7:0] k, input logic hit, input logic [7:0] v);
    bit ok = 0;
    sb.push_back({hit, v, k});
    rd_valid = 1'b1; rd_key = k;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clock);
      ok = rd_ready;
    end
    @(posedge clock); #1;
    rd_valid = 1'b0;
    vectors++;
    if (!ok || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency key=%h out_valid=%b required 1 one cycle after accept", k, out_valid);
    end
  endtask

  task automatic do_del(input logic kv, input logic [7:0] k, input logic vv, input logic [7:0] v);
    kdel_valid = kv; kdel_key = k; vdel_valid = vv; vdel_val = v;
    @(posedge clock); #1;
    kdel_valid = 1'b0; vdel_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    sb.delete();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_valid = 0; wr_key = 0; wr_val = 0;
    rd_valid = 0; rd_key = 0;
    kdel_valid = 0; kdel_key = 0; vdel_valid = 0; vdel_val = 0;
    out_ready = 1'b1;
    #12;
    vectors++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy got %0d required 0", occupancy); end
    vectors++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b required 0", full); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    vectors++; if ({out_hit, out_val, out_key} !== 17'd0) begin errors++; $display("FAIL rst_out_fields got hit=%b val=%h key=%h required zeros", out_hit, out_val, out_key); end
    vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b required 1", wr_ready); end
    vectors++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rst_rd_ready got %b required 1", rd_ready); end
    vectors++; if (kdel_ready !== 1'b1 || vdel_ready !== 1'b1) begin errors++; $display("FAIL rst_del_ready got k=%b v=%b required 1 1", kdel_ready, vdel_ready); end
    rst = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_insert_lookup();
    do_write(8'h11, 8'hA1);
    do_write(8'h22, 8'hB2);
    do_lookup(8'h22, 1'b1, 8'hB2);
    vectors++; if (occupancy !== 3'd2) begin errors++; $display("FAIL ins_occupancy got %0d required 2", occupancy); end
    idle(2);
  endtask

  task automatic test_update_miss();
    do_write(8'h11, 8'hC3);
    do_lookup(8'h11, 1'b1, 8'hC3);
    vectors++; if (occupancy !== 3'd2) begin errors++; $display("FAIL upd_occupancy got %0d required 2", occupancy); end
    do_lookup(8'h99, 1'b0, 8'h00);
    idle(2);
  endtask

  task automatic test_deletes();
    pulse_reset();
    for (int i = 1; i <= 4; i++) do_write(8'(i), 8'h55);
    vectors++; if (full !== 1'b1 || occupancy !== 3'd4) begin errors++; $display("FAIL del_fill got occ=%0d full=%b required 4 1", occupancy, full); end
    do_del(1'b0, 8'h00, 1'b1, 8'h55);
    vectors++; if (full !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL vdel_all got occ=%0d full=%b required 0 0", occupancy, full); end
    for (int i = 1; i <= 4; i++) do_write(8'(i), 8'(i * 16));
    do_del(1'b1, 8'h02, 1'b1, 8'h30);
    vectors++; if (occupancy !== 3'd2) begin errors++; $display("FAIL dual_del_occupancy got %0d required 2", occupancy); end
    do_lookup(8'h02, 1'b0, 8'h00);
    do_lookup(8'h03, 1'b0, 8'h00);
    do_lookup(8'h04, 1'b1, 8'h40);
    do_del(1'b1, 8'h66, 1'b1, 8'h99);
    vectors++; if (occupancy !== 3'd2) begin errors++; $display("FAIL absent_del_occupancy got %0d required 2", occupancy); end
    // Lookup issued in the same cycle as the delete of its key still hits.
    sb.push_back({1'b1, 8'h10, 8'h01});
    rd_valid = 1'b1; rd_key = 8'h01;
    kdel_valid = 1'b1; kdel_key = 8'h01;
    @(posedge clock); #1;
    rd_valid = 1'b0; kdel_valid = 1'b0;
    vectors++; if (occupancy !== 3'd1) begin errors++; $display("FAIL kdel_rd_occupancy got %0d required 1", occupancy); end
    do_lookup(8'h01, 1'b0, 8'h00);
    idle(2);
  endtask

  task automatic test_full_policy();
    pulse_reset();
    for (int i = 1; i <= 4; i++) do_write(8'(i), 8'(i * 16));
    vectors++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b required 1", full); end
`ifdef DATA_PAIR_MAP_B1_EVICT_EN
    wr_valid = 1'b1; wr_key = 8'h77; wr_val = 8'hE7;
    #1;
    vectors++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL evict_wr_ready got %b required 1", wr_ready); end
    do_write(8'h77, 8'hE7);
    do_lookup(8'h01, 1'b0, 8'h00);
    do_lookup(8'h77, 1'b1, 8'hE7);
    do_write(8'h88, 8'hE8);
    do_lookup(8'h02, 1'b0, 8'h00);
    do_lookup(8'h88, 1'b1, 8'hE8);
    do_lookup(8'h03, 1'b1, 8'h30);
    vectors++; if (occupancy !== 3'd4) begin errors++; $display("FAIL evict_occupancy got %0d required 4", occupancy); end
`else
    wr_valid = 1'b1; wr_key = 8'h77; wr_val = 8'hE7;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      vectors++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_stall cycle %0d got %b required 0", n, wr_ready); end
    end
    vectors++; if (kdel_ready !== 1'b0) begin errors++; $display("FAIL kdel_stall got %b required 0", kdel_ready); end
    @(posedge clock); #1;
    wr_valid = 1'b0;
    do_write(8'h02, 8'h2A);
    do_del(1'b1, 8'h01, 1'b0, 8'h00);
    vectors++; if (occupancy !== 3'd3 || full !== 1'b0) begin errors++; $display("FAIL full_kdel got occ=%0d full=%b required 3 0", occupancy, full); end
    do_write(8'h77, 8'hE7);
    vectors++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_refill_occupancy got %0d required 4", occupancy); end
    do_lookup(8'h77, 1'b1, 8'hE7);
    do_lookup(8'h01, 1'b0, 8'h00);
    do_lookup(8'h02, 1'b1, 8'h2A);
`endif
    idle(2);
  endtask

  task automatic test_backpressure();
    pulse_reset();
    do_write(8'h11, 8'hA1);
    do_write(8'h22, 8'hB2);
    do_write(8'h33, 8'hC3);
    out_ready = 1'b0;
    sb.push_back({1'b1, 8'hA1, 8'h11});
    rd_valid = 1'b1; rd_key = 8'h11;
    @(negedge clock);
    vectors++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL bp_first_rd_ready got %b required 1", rd_ready); end
    @(posedge clock); #1;
    sb.push_back({1'b1, 8'hB2, 8'h22});
    rd_key = 8'h22;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      vectors++;
      if (rd_ready !== 1'b0 || out_valid !== 1'b1 || out_key !== 8'h11 || out_val !== 8'hA1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got rd_ready=%b out_valid=%b key=%h val=%h required 0 1 11 a1",
                 n, rd_ready, out_valid, out_key, out_val);
      end
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    sb.push_back({1'b1, 8'hC3, 8'h33});
    rd_key = 8'h33;
    @(posedge clock); #1;
    rd_valid = 1'b0;
    idle(2);
    // Write and lookup of the same key in one cycle: lookup sees the old value.
    sb.push_back({1'b1, 8'hA1, 8'h11});
    wr_valid = 1'b1; wr_key = 8'h11; wr_val = 8'hD4;
    rd_valid = 1'b1; rd_key = 8'h11;
    @(posedge clock); #1;
    wr_valid = 1'b0; rd_valid = 1'b0;
    do_lookup(8'h11, 1'b1, 8'hD4);
    idle(2);
  endtask

  task automatic test_reset_mid();
    vectors++; if (occupancy !== 3'd3) begin errors++; $display("FAIL mid_pre_occupancy got %0d required 3", occupancy); end
    out_ready = 1'b0;
    do_lookup(8'h22, 1'b1, 8'hB2);
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b required 0", out_valid); end
    vectors++; if (occupancy !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL mid_rst_occ got occ=%0d full=%b required 0 0", occupancy, full); end
    sb.delete();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    do_lookup(8'h11, 1'b0, 8'h00);
    do_lookup(8'h22, 1'b0, 8'h00);
    do_lookup(8'h33, 1'b0, 8'h00);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_insert_lookup();
    test_update_miss();
    test_deletes();
    test_full_policy();
    test_backpressure();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending results required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
